// File: rtl/w21_neuron_mac.sv
// w21_neuron_mac: output-layer neuron engine, column 7 of the layer-2 weights.
// Walks adrs_clm over 0..N_IN-1 into a combinational weight ROM and activation
// buffer, multiplies each signed pair and accumulates the exact dot product.
// Ports: clk, rst (sync, active high), start | weight_in, act_in (same-cycle
//   data for adrs_clm) | adrs_clm, busy, done (1-cycle pulse), result (held).
// Latency: done appears N_IN+2 cycles after start is accepted; start is only
//   sampled in IDLE, so requests while busy or during done are dropped.
// Optional feature: define W21_NEURON_RELU_EN to clamp a negative sum to 0.

module w21_neuron_mac #(
  parameter int N_IN   = 300,
  parameter int ADRS_W = 9,
  parameter int W_W    = 21,
  parameter int ACT_W  = 16,
  parameter int ACC_W  = 46
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_W-1:0]    weight_in,
  input  logic [ACT_W-1:0]  act_in,
  output logic [ADRS_W-1:0] adrs_clm,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result
);

  localparam int PROD_W = W_W + ACT_W;
  localparam logic [ADRS_W-1:0] LAST = ADRS_W'(N_IN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [ADRS_W-1:0]        idx;
  logic signed [PROD_W-1:0] w_ext, a_ext, prod_mul, prod;
  logic                     prod_vld;
  logic signed [ACC_W-1:0]  acc, prod_ext, sum_last, result_nxt;

  // Both operands sign-extended to the full product width so the multiply
  // is exact and carries no implicit width conversion.
  assign w_ext    = PROD_W'($signed(weight_in));
  assign a_ext    = PROD_W'($signed(act_in));
  assign prod_mul = w_ext * a_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Sum including the final registered product, written to result in DRAIN.
  assign sum_last = acc + prod_ext;

`ifdef W21_NEURON_RELU_EN
  assign result_nxt = sum_last[ACC_W-1] ? '0 : sum_last;
`else
  assign result_nxt = sum_last;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs (Moore)
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    adrs_clm = '0;
    case (state)
      IDLE:    adrs_clm = '0;
      RUN:     adrs_clm = idx;
      DRAIN:   adrs_clm = LAST;
      DONE:    adrs_clm = LAST;
      default: adrs_clm = '0;
    endcase
  end

  // Datapath: one-stage product pipeline feeding the accumulator. The product
  // of address k is added while address k+1 is being multiplied, so the last
  // product is folded in during DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            acc      <= '0;
            prod_vld <= 1'b0;
            result   <= '0;
          end
        end
        RUN: begin
          prod     <= prod_mul;
          prod_vld <= 1'b1;
          if (prod_vld) acc <= acc + prod_ext;
          // Stop at the last address so the ROM is never addressed past it.
          if (idx != LAST) idx <= idx + ADRS_W'(1);
        end
        DRAIN: begin
          acc      <= sum_last;
          result   <= result_nxt;
          prod_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_w21_neuron_mac.sv
module tb_w21_neuron_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [20:0] weight_in;
  logic [15:0] act_in;
  logic [8:0]  adrs_clm;
  logic        busy;
  logic        done;
  logic [45:0] result;

  w21_neuron_mac dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .weight_in (weight_in),
    .act_in    (act_in),
    .adrs_clm  (adrs_clm),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int exp_done = 0;
  int adrs_bad = 0;
  int seq_err  = 0;
  int base     = 0;
  bit seq_on   = 1'b0;
  bit prev_done = 1'b0;
  int mode     = 0;

  longint exp_res_q[$];
  int     start_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint relu(input longint v);
`ifdef W21_NEURON_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Stimulus ROM / activation buffer models, combinational on adrs_clm.
  function automatic logic [20:0] wrom(input int m, input int a);
    case (m)
      0, 3:    return 21'(a - 150);
      1:       return (a == 299) ? 21'h100000 : 21'h0;
      2:       return 21'd1000;
      4:       return 21'h100000;
      5:       return 21'(a);
      default: return 21'h0;
    endcase
  endfunction

  function automatic logic [15:0] arom(input int m, input int a);
    case (m)
      0, 5:    return 16'd1;
      1:       return (a == 299) ? 16'h8000 : 16'h0;
      2:       return 16'hFFFF;
      3:       return 16'd2;
      4:       return 16'd32767;
      default: return 16'h0;
    endcase
  endfunction

  always_comb begin
    weight_in = wrom(mode, int'(adrs_clm));
    act_in    = arom(mode, int'(adrs_clm));
  end

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (adrs_clm > 9'd299) adrs_bad++;
    if (!rst) begin
      if (seq_on && cyc >= base + 1 && cyc <= base + 300 &&
          int'(adrs_clm) != cyc - base - 1) seq_err++;
      if (prev_done) check("busy_after_done", longint'(busy), 0);
      if (done) begin
        n_done++;
        if (exp_res_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("result_at_done", longint'($signed(result)), exp_res_q.pop_front());
          check("done_latency", longint'(cyc - start_q.pop_front()), 302);
        end
      end
    end
    prev_done = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_start(input int m, input longint e);
    mode    = m;
    start   = 1'b1;
    base    = cyc;
    seq_err = 0;
    seq_on  = 1'b1;
    exp_res_q.push_back(e);
    start_q.push_back(cyc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, longint'(seen), 1);
  endtask

  task automatic pulse_at(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  typedef struct {
    int     mode;
    longint exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int b;
    vecs[0] = '{0, relu(-64'sd150)};
    vecs[1] = '{1, relu(64'sd34359738368)};
    vecs[2] = '{2, relu(-64'sd300000)};
    vecs[3] = '{4, relu(-64'sd1048576 * 64'sd32767 * 64'sd300)};
    vecs[4] = '{5, relu(64'sd44850)};

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",   longint'(busy), 0);
    check("reset_done",   longint'(done), 0);
    check("reset_adrs",   longint'(adrs_clm), 0);
    check("reset_result", longint'(result), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven dot products
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      do_start(vecs[i].mode, vecs[i].exp);
      exp_done++;
      wait_done(400, $sformatf("done_seen_v%0d", i));
      check($sformatf("adrs_seq_v%0d", i), longint'(seq_err), 0);
      check($sformatf("busy_in_done_v%0d", i), longint'(busy), 1);
      @(posedge clk); #1;
      check($sformatf("result_held_v%0d", i), longint'($signed(result)), vecs[i].exp);
      check($sformatf("idle_busy_v%0d", i), longint'(busy), 0);
    end

    // start re-pulsed while busy, in DRAIN and coincident with done
    @(posedge clk); #1;
    do_start(0, relu(-64'sd150));
    exp_done++;
    b = base;
    pulse_at(b + 10);
    pulse_at(b + 150);
    pulse_at(b + 301);
    pulse_at(b + 302);
    repeat (20) @(posedge clk);
    #1;
    check("repulse_no_restart", longint'(busy), 0);
    check("repulse_done_count", longint'(n_done), longint'(exp_done));
    check("repulse_adrs_seq", longint'(seq_err), 0);

    // Reset in the middle of a run, then a fresh run
    do_start(0, relu(-64'sd150));
    b = base;
    while (cyc < b + 101) begin
      @(posedge clk); #1;
    end
    check("abort_busy_before", longint'(busy), 1);
    check("abort_adrs_before", longint'(adrs_clm), 100);
    rst    = 1'b1;
    seq_on = 1'b0;
    exp_res_q.delete();
    start_q.delete();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_busy",   longint'(busy), 0);
      check("abort_done",   longint'(done), 0);
      check("abort_adrs",   longint'(adrs_clm), 0);
      check("abort_result", longint'(result), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_start(0, relu(-64'sd150));
    exp_done++;
    wait_done(400, "done_seen_after_abort");
    check("adrs_seq_after_abort", longint'(seq_err), 0);

    // Back-to-back: second start in the IDLE cycle right after done
    @(posedge clk); #1;
    do_start(0, relu(-64'sd150));
    exp_done++;
    wait_done(400, "done_seen_b2b_first");
    @(posedge clk); #1;
    check("b2b_result_held", longint'($signed(result)), relu(-64'sd150));
    do_start(3, relu(-64'sd300));
    exp_done++;
    check("b2b_result_cleared", longint'(result), 0);
    check("b2b_busy", longint'(busy), 1);
    wait_done(400, "done_seen_b2b_second");
    check("adrs_seq_b2b", longint'(seq_err), 0);
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", longint'(exp_res_q.size()), 0);
    check("done_count", longint'(n_done), longint'(exp_done));
    check("adrs_range", longint'(adrs_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
